register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter NR, default 32, meaning register count (4..32).
REQ-002 SHALL have parameter NRP, default 3, meaning read-port count (left, right, address).
REQ-003 SHALL have parameter W, default 32, meaning register width.
REQ-004 SHALL have port clock  in  1  meaning the only clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port hold  in  1  meaning a downstream stall that blocks issue.
REQ-007 SHALL have port pc  in  W  meaning the current PC value, supplied by fetch.
REQ-008 SHALL have port read_index  in  NRP x 5  meaning the regind_t selector per read port.
REQ-009 SHALL have port read_value  out  NRP x W  meaning the read data per port.
REQ-010 SHALL have port read_busy  out  NRP  meaning the selected register has a pending producer.
REQ-011 SHALL have ports issue_valid  in  1 and issue_register  in  5, meaning a new producer is issued.
REQ-012 SHALL have ports write_enable  in  1, write_register  in  5 and write_value  in  W, meaning the write-back port.
REQ-013 SHALL have ports flags_enable  in  1 and flags_value  in  4, meaning the ALU flags update.
REQ-014 SHALL have ports pc_write  out  1 and pc_target  out  W, meaning a registered branch request.

Function
REQ-015 SHALL give Flags index NR-1 and PC index NR-2; register 0 SHALL always read 0 and ignore writes.
REQ-016 SHALL read 0 when read_index >= NR; read_value SHALL be combinational from read_index.
REQ-017 SHALL return the pc input on any read of the PC index, never stored state.
REQ-018 SHALL not store a write to the PC index; the next edge SHALL set pc_write=1 and pc_target=write_value for exactly one cycle.
REQ-019 SHALL make a write to any other index 1..NR-1 visible from the following cycle.
REQ-020 SHALL, when flags_enable is high, load flags_value into Flags[3:0] and clear Flags[W-1:4].
REQ-021 SHALL give a general write to Flags priority over flags_enable in the same cycle.
REQ-022 SHALL keep one busy bit per register: issue_valid && !hold sets busy[issue_register], except registers 0 and PC.
REQ-023 SHALL clear busy[write_register] on write_enable.
REQ-024 SHALL let set win when set and clear hit the same register in the same cycle.
REQ-025 SHALL drive read_busy[i]=busy[read_index[i]] (subject to REQ-029); it SHALL be 0 for index 0, the PC index and out-of-range indices.
REQ-026 SHALL never block writes with hold.

Reset
REQ-027 SHALL on reset_n low, immediately and asynchronously, clear all registers, Flags, busy bits, pc_write and pc_target to 0.
REQ-028 SHALL discard any write or issue in the cycle reset deasserts if reset_n is sampled low at that edge.

Configuration
REQ-029 SHALL, with REGISTER_FILE_BYPASS_EN defined, forward write_value to any read port whose index equals write_register (not 0 or PC) when write_enable is high in the same cycle, and SHALL clear that port's read_busy.
REQ-030 SHALL, without REGISTER_FILE_BYPASS_EN, return the old value and keep read_busy=1 for that cycle.

Structure
REQ-031 SHALL place regind_t, regval_t, NR default, Flags/PC index functions and the Nop constant in shared package regs_pkg.
REQ-032 SHALL implement the busy-bit tracking in sub-module register_scoreboard (set, clear, NRP lookups).

Verification
REQ-033 SHALL cover: write r5=0x12345678, next cycle read r5 -> 0x12345678, read_busy=0.
REQ-034 SHALL cover: write r0=0xFFFFFFFF; read r0 -> 0; read PC index with pc=0x100 -> 0x100.
REQ-035 SHALL cover: write PC index 0x2000 -> next cycle pc_write=1, pc_target=0x2000, then pc_write=0.
REQ-036 SHALL cover: issue r7, read r7 -> busy=1; same-cycle write r7=9: with bypass, value 9 and busy 0; without, old value and busy 1.
REQ-037 SHALL cover: issue r3 with hold=1 -> busy stays 0; issue r3 and write r3 together -> busy=1.
REQ-038 SHALL cover: flags_enable=1 with flags 0xA while writing Flags=0x55 -> Flags=0x55; reset_n low mid-sequence -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/regs_pkg.sv
// Shared register-file types, index helpers and constants.
package regs_pkg;

  typedef logic [4:0]  regind_t;
  typedef logic [31:0] regval_t;

  localparam int unsigned NR_DEFAULT = 32;
  localparam int unsigned FLAGS_W    = 4;
  localparam regval_t     NOP        = 32'h0000_0000;

  function automatic regind_t flags_index(input int unsigned nr);
    return regind_t'(nr - 1);
  endfunction

  function automatic regind_t pc_index(input int unsigned nr);
    return regind_t'(nr - 2);
  endfunction

  // True for indices backed by real storage and busy tracking: not r0, not PC, in range.
  function automatic logic is_tracked(input regind_t idx, input int unsigned nr);
    return (idx != '0) && (idx != pc_index(nr)) && (32'(idx) < nr);
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Register-file access bus: read ports, issue, write-back, flags and branch request.
interface register_file_if #(
  parameter int unsigned NRP = 3,
  parameter int unsigned W   = 32
);

  logic                              hold;
  logic [W-1:0]                      pc;
  regs_pkg::regind_t [NRP-1:0]       read_index;
  logic [NRP-1:0][W-1:0]             read_value;
  logic [NRP-1:0]                    read_busy;
  logic                              issue_valid;
  regs_pkg::regind_t                 issue_register;
  logic                              write_enable;
  regs_pkg::regind_t                 write_register;
  logic [W-1:0]                      write_value;
  logic                              flags_enable;
  logic [regs_pkg::FLAGS_W-1:0]      flags_value;
  logic                              pc_write;
  logic [W-1:0]                      pc_target;

  modport master (
    output hold, pc, read_index, issue_valid, issue_register,
           write_enable, write_register, write_value, flags_enable, flags_value,
    input  read_value, read_busy, pc_write, pc_target
  );

  modport slave (
    input  hold, pc, read_index, issue_valid, issue_register,
           write_enable, write_register, write_value, flags_enable, flags_value,
    output read_value, read_busy, pc_write, pc_target
  );

endinterface

// File: rtl/register_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register, set-over-clear, NRP lookups.
module register_scoreboard
  import regs_pkg::*;
#(
  parameter int unsigned NR  = NR_DEFAULT,
  parameter int unsigned NRP = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_set_valid,
  input  regind_t             i_set_index,
  input  logic                i_clr_valid,
  input  regind_t             i_clr_index,
  input  regind_t [NRP-1:0]   i_lookup_index,
  output logic    [NRP-1:0]   o_lookup_busy
);

  logic [31:0] r_busy;
  logic [31:0] w_busy_next;

  // Clear is applied first so a same-cycle set on the same register wins.
  always_comb begin
    w_busy_next = r_busy;
    if (i_clr_valid) begin
      w_busy_next[i_clr_index] = 1'b0;
    end
    if (i_set_valid && is_tracked(i_set_index, NR)) begin
      w_busy_next[i_set_index] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  for (genvar gp = 0; gp < NRP; gp++) begin : g_lookup
    assign o_lookup_busy[gp] = is_tracked(i_lookup_index[gp], NR) && r_busy[i_lookup_index[gp]];
  end

endmodule

// File: rtl/register_file.sv
// Register file with r0=0, PC pass-through, Flags register and busy scoreboard.
// Optional same-cycle write-to-read forwarding under REGISTER_FILE_BYPASS_EN.
module register_file
  import regs_pkg::*;
#(
  parameter int unsigned NR  = NR_DEFAULT,
  parameter int unsigned NRP = 3,
  parameter int unsigned W   = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  register_file_if.slave  bus
);

  localparam regind_t FLAGS_IDX = flags_index(NR);
  localparam regind_t PC_IDX    = pc_index(NR);

  logic [W-1:0]   r_regs [32];
  logic           r_pc_write;
  logic [W-1:0]   r_pc_target;

  logic           w_wr_gen;
  logic           w_wr_pc;
  logic [NRP-1:0] w_sb_busy;

  assign w_wr_gen = bus.write_enable && is_tracked(bus.write_register, NR);
  assign w_wr_pc  = bus.write_enable && (bus.write_register == PC_IDX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_regs      <= '{default: '0};
      r_pc_write  <= 1'b0;
      r_pc_target <= '0;
    end else begin
      r_pc_write <= w_wr_pc;
      if (w_wr_pc) begin
        r_pc_target <= bus.write_value;
      end
      if (bus.flags_enable) begin
        r_regs[FLAGS_IDX] <= W'(bus.flags_value);
      end
      // Later assignment wins, giving a general write to Flags priority over flags_enable.
      if (w_wr_gen) begin
        r_regs[bus.write_register] <= bus.write_value;
      end
    end
  end

  register_scoreboard #(
    .NR  (NR),
    .NRP (NRP)
  ) u_scoreboard (
    .clock          (clock),
    .reset_n        (reset_n),
    .i_set_valid    (bus.issue_valid && !bus.hold),
    .i_set_index    (bus.issue_register),
    .i_clr_valid    (bus.write_enable),
    .i_clr_index    (bus.write_register),
    .i_lookup_index (bus.read_index),
    .o_lookup_busy  (w_sb_busy)
  );

  for (genvar gp = 0; gp < NRP; gp++) begin : g_read
    logic [W-1:0] w_value;
    logic         w_busy;

    always_comb begin
      w_value = '0;
      w_busy  = 1'b0;
      if (bus.read_index[gp] == PC_IDX) begin
        w_value = bus.pc;
      end else if (is_tracked(bus.read_index[gp], NR)) begin
        w_value = r_regs[bus.read_index[gp]];
        w_busy  = w_sb_busy[gp];
      end
`ifdef REGISTER_FILE_BYPASS_EN
      if (w_wr_gen && (bus.write_register == bus.read_index[gp])) begin
        w_value = bus.write_value;
        w_busy  = 1'b0;
      end
`endif
    end

    assign bus.read_value[gp] = w_value;
    assign bus.read_busy[gp]  = w_busy;
  end

  assign bus.pc_write  = r_pc_write;
  assign bus.pc_target = r_pc_target;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default NR=32 plus a small NR=16 instance).
module tb_register_file;
  import regs_pkg::*;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  register_file_if #(.NRP(3), .W(32)) bus ();
  register_file_if #(.NRP(3), .W(32)) bus_s ();

  register_file #(.NR(32), .NRP(3), .W(32)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  register_file #(.NR(16), .NRP(3), .W(32)) u_small (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_s.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.hold           = 1'b0;
    bus.pc             = '0;
    bus.issue_valid    = 1'b0;
    bus.issue_register = '0;
    bus.write_enable   = 1'b0;
    bus.write_register = '0;
    bus.write_value    = '0;
    bus.flags_enable   = 1'b0;
    bus.flags_value    = '0;
  endtask

  task automatic idle_small();
    bus_s.hold           = 1'b0;
    bus_s.pc             = '0;
    bus_s.read_index     = '0;
    bus_s.issue_valid    = 1'b0;
    bus_s.issue_register = '0;
    bus_s.write_enable   = 1'b0;
    bus_s.write_register = '0;
    bus_s.write_value    = '0;
    bus_s.flags_enable   = 1'b0;
    bus_s.flags_value    = '0;
  endtask

  task automatic write_reg(input regind_t idx, input logic [31:0] val);
    bus.write_enable   = 1'b1;
    bus.write_register = idx;
    bus.write_value    = val;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    idle_small();
    bus.read_index = '{5'd5, 5'd0, 5'd31};
    #12;
    checks++; if (bus.read_value[0] !== 32'h0) begin errors++; $display("FAIL reset_flags: got %h expected %h", bus.read_value[0], 32'h0); end
    checks++; if (bus.read_value[2] !== 32'h0) begin errors++; $display("FAIL reset_r5: got %h expected %h", bus.read_value[2], 32'h0); end
    checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL reset_pc_write: got %b expected 0", bus.pc_write); end
    checks++; if (bus.pc_target !== 32'h0) begin errors++; $display("FAIL reset_pc_target: got %h expected %h", bus.pc_target, 32'h0); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    write_reg(5'd5, 32'h1234_5678);
    bus.read_index = '{5'd0, 5'd5, 5'd5};
    #1;
    checks++; if (bus.read_value[0] !== 32'h1234_5678) begin errors++; $display("FAIL r5_value: got %h expected %h", bus.read_value[0], 32'h1234_5678); end
    checks++; if (bus.read_busy[0] !== 1'b0) begin errors++; $display("FAIL r5_busy: got %b expected 0", bus.read_busy[0]); end
    checks++; if (bus.read_value[1] !== 32'h1234_5678) begin errors++; $display("FAIL r5_port1: got %h expected %h", bus.read_value[1], 32'h1234_5678); end
  endtask

  task automatic test_r0_pc();
    write_reg(5'd0, 32'hFFFF_FFFF);
    bus.pc = 32'h100;
    bus.read_index = '{5'd0, 5'd30, 5'd0};
    #1;
    checks++; if (bus.read_value[0] !== 32'h0) begin errors++; $display("FAIL r0_value: got %h expected %h", bus.read_value[0], 32'h0); end
    checks++; if (bus.read_value[1] !== 32'h100) begin errors++; $display("FAIL pc_read: got %h expected %h", bus.read_value[1], 32'h100); end
    checks++; if (bus.read_busy[1] !== 1'b0) begin errors++; $display("FAIL pc_busy: got %b expected 0", bus.read_busy[1]); end
  endtask

  task automatic test_pc_write();
    bus.write_enable   = 1'b1;
    bus.write_register = 5'd30;
    bus.write_value    = 32'h2000;
    #1;
    checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL pc_write_early: got %b expected 0", bus.pc_write); end
    tick();
    idle();
    bus.pc = 32'h100;
    bus.read_index = '{5'd0, 5'd0, 5'd30};
    #1;
    checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL pc_write_pulse: got %b expected 1", bus.pc_write); end
    checks++; if (bus.pc_target !== 32'h2000) begin errors++; $display("FAIL pc_target: got %h expected %h", bus.pc_target, 32'h2000); end
    checks++; if (bus.read_value[0] !== 32'h100) begin errors++; $display("FAIL pc_not_stored: got %h expected %h", bus.read_value[0], 32'h100); end
    tick();
    checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL pc_write_end: got %b expected 0", bus.pc_write); end
  endtask

  task automatic test_busy_bypass();
    write_reg(5'd7, 32'h77);
    bus.issue_valid    = 1'b1;
    bus.issue_register = 5'd7;
    tick();
    idle();
    bus.read_index = '{5'd0, 5'd0, 5'd7};
    #1;
    checks++; if (bus.read_busy[0] !== 1'b1) begin errors++; $display("FAIL r7_busy_set: got %b expected 1", bus.read_busy[0]); end
    checks++; if (bus.read_value[0] !== 32'h77) begin errors++; $display("FAIL r7_old: got %h expected %h", bus.read_value[0], 32'h77); end
    bus.write_enable   = 1'b1;
    bus.write_register = 5'd7;
    bus.write_value    = 32'd9;
    #1;
`ifdef REGISTER_FILE_BYPASS_EN
    checks++; if (bus.read_value[0] !== 32'd9) begin errors++; $display("FAIL r7_bypass_value: got %h expected %h", bus.read_value[0], 32'd9); end
    checks++; if (bus.read_busy[0] !== 1'b0) begin errors++; $display("FAIL r7_bypass_busy: got %b expected 0", bus.read_busy[0]); end
`else
    checks++; if (bus.read_value[0] !== 32'h77) begin errors++; $display("FAIL r7_nobypass_value: got %h expected %h", bus.read_value[0], 32'h77); end
    checks++; if (bus.read_busy[0] !== 1'b1) begin errors++; $display("FAIL r7_nobypass_busy: got %b expected 1", bus.read_busy[0]); end
`endif
    tick();
    idle();
    #1;
    checks++; if (bus.read_value[0] !== 32'd9) begin errors++; $display("FAIL r7_written: got %h expected %h", bus.read_value[0], 32'd9); end
    checks++; if (bus.read_busy[0] !== 1'b0) begin errors++; $display("FAIL r7_busy_clr: got %b expected 0", bus.read_busy[0]); end
  endtask

  task automatic test_hold();
    bus.read_index = '{5'd0, 5'd0, 5'd3};
    bus.hold           = 1'b1;
    bus.issue_valid    = 1'b1;
    bus.issue_register = 5'd3;
    tick();
    idle();
    #1;
    checks++; if (bus.read_busy[0] !== 1'b0) begin errors++; $display("FAIL r3_hold_busy: got %b expected 0", bus.read_busy[0]); end
    bus.issue_valid    = 1'b1;
    bus.issue_register = 5'd3;
    bus.write_enable   = 1'b1;
    bus.write_register = 5'd3;
    bus.write_value    = 32'h33;
    tick();
    idle();
    #1;
    checks++; if (bus.read_busy[0] !== 1'b1) begin errors++; $display("FAIL r3_set_wins: got %b expected 1", bus.read_busy[0]); end
    checks++; if (bus.read_value[0] !== 32'h33) begin errors++; $display("FAIL r3_value: got %h expected %h", bus.read_value[0], 32'h33); end
    bus.hold = 1'b1;
    write_reg(5'd3, 32'h44);
    #1;
    checks++; if (bus.read_value[0] !== 32'h44) begin errors++; $display("FAIL r3_write_under_hold: got %h expected %h", bus.read_value[0], 32'h44); end
    checks++; if (bus.read_busy[0] !== 1'b0) begin errors++; $display("FAIL r3_busy_cleared: got %b expected 0", bus.read_busy[0]); end
  endtask

  task automatic test_flags();
    write_reg(5'd31, 32'hFFFF_FFF0);
    bus.read_index = '{5'd0, 5'd0, 5'd31};
    bus.flags_enable = 1'b1;
    bus.flags_value  = 4'hA;
    tick();
    idle();
    #1;
    checks++; if (bus.read_value[0] !== 32'h0000_000A) begin errors++; $display("FAIL flags_load: got %h expected %h", bus.read_value[0], 32'h0000_000A); end
    bus.flags_enable   = 1'b1;
    bus.flags_value    = 4'hA;
    bus.write_enable   = 1'b1;
    bus.write_register = 5'd31;
    bus.write_value    = 32'h55;
    tick();
    idle();
    #1;
    checks++; if (bus.read_value[0] !== 32'h55) begin errors++; $display("FAIL flags_priority: got %h expected %h", bus.read_value[0], 32'h55); end
  endtask

  task automatic test_async_reset();
    bus.issue_valid    = 1'b1;
    bus.issue_register = 5'd9;
    bus.write_enable   = 1'b1;
    bus.write_register = 5'd30;
    bus.write_value    = 32'hBEEF;
    tick();
    idle();
    bus.read_index = '{5'd31, 5'd9, 5'd5};
    #1;
    checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL pre_reset_pc_write: got %b expected 1", bus.pc_write); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.read_value[0] !== 32'h0) begin errors++; $display("FAIL async_r5: got %h expected %h", bus.read_value[0], 32'h0); end
    checks++; if (bus.read_busy[1] !== 1'b0) begin errors++; $display("FAIL async_busy9: got %b expected 0", bus.read_busy[1]); end
    checks++; if (bus.read_value[2] !== 32'h0) begin errors++; $display("FAIL async_flags: got %h expected %h", bus.read_value[2], 32'h0); end
    checks++; if (bus.pc_write !== 1'b0) begin errors++; $display("FAIL async_pc_write: got %b expected 0", bus.pc_write); end
    checks++; if (bus.pc_target !== 32'h0) begin errors++; $display("FAIL async_pc_target: got %h expected %h", bus.pc_target, 32'h0); end
    bus.write_enable   = 1'b1;
    bus.write_register = 5'd5;
    bus.write_value    = 32'hDEAD;
    bus.issue_valid    = 1'b1;
    bus.issue_register = 5'd5;
    tick();
    idle();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checks++; if (bus.read_value[0] !== 32'h0) begin errors++; $display("FAIL reset_discard_write: got %h expected %h", bus.read_value[0], 32'h0); end
    checks++; if (bus.read_busy[0] !== 1'b0) begin errors++; $display("FAIL reset_discard_issue: got %b expected 0", bus.read_busy[0]); end
  endtask

  task automatic test_small_range();
    bus_s.write_enable   = 1'b1;
    bus_s.write_register = 5'd20;
    bus_s.write_value    = 32'hABCD;
    bus_s.issue_valid    = 1'b1;
    bus_s.issue_register = 5'd20;
    tick();
    bus_s.issue_valid    = 1'b1;
    bus_s.issue_register = 5'd14;
    bus_s.write_enable   = 1'b0;
    bus_s.flags_enable   = 1'b1;
    bus_s.flags_value    = 4'h3;
    tick();
    idle_small();
    bus_s.pc = 32'h40;
    bus_s.read_index = '{5'd15, 5'd14, 5'd20};
    #1;
    checks++; if (bus_s.read_value[0] !== 32'h0) begin errors++; $display("FAIL oor_value: got %h expected %h", bus_s.read_value[0], 32'h0); end
    checks++; if (bus_s.read_busy[0] !== 1'b0) begin errors++; $display("FAIL oor_busy: got %b expected 0", bus_s.read_busy[0]); end
    checks++; if (bus_s.read_value[1] !== 32'h40) begin errors++; $display("FAIL small_pc: got %h expected %h", bus_s.read_value[1], 32'h40); end
    checks++; if (bus_s.read_busy[1] !== 1'b0) begin errors++; $display("FAIL small_pc_busy: got %b expected 0", bus_s.read_busy[1]); end
    checks++; if (bus_s.read_value[2] !== 32'h3) begin errors++; $display("FAIL small_flags: got %h expected %h", bus_s.read_value[2], 32'h3); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_r0_pc();
    test_pc_write();
    test_busy_bypass();
    test_hold();
    test_flags();
    test_async_reset();
    test_small_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
